// File: rtl/idm_pkg.sv
// Shared definitions for the IDM responder: FSM encoding, wait-counter width
// and request-type codes.
package idm_pkg;

   localparam int unsigned CNT_W = 4;

   localparam logic IDM_RD = 1'b0;
   localparam logic IDM_WR = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } idm_state_e;

endpackage

// File: rtl/idm_ram.sv
// DEPTH x DATA_W word RAM: preload and request write ports, registered read.
// A request write on the same edge and address as a preload lands last.
module idm_ram #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic              rd_zero,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data_q;
   logic [DATA_W-1:0] rd_data_d;

   always_ff @(posedge clk) begin
      if (ld_en) mem[ld_addr] <= ld_data;
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // Read register holds its value until the next read or range-error clear.
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) rd_data_d = rd_zero ? '0 : mem[rd_addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_data_q <= '0;
      else        rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/idm_responder.sv
// Memory-side responder for the shared instruction/data port: one request at a
// time, WAIT_CYC wait states, one-cycle Ack, plus a preload port usable in IDLE.
module idm_responder
   import idm_pkg::*;
#(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned DEPTH    = 256,
   parameter int unsigned WAIT_CYC = 2
) (
   input  logic              CLK,
   input  logic              RST_n,
   input  logic              Req,
   input  logic              IDMWrite,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] WData,
   output logic [DATA_W-1:0] RData,
   output logic              Ack,
   output logic              Err,
   output logic              Busy,
   input  logic              LdEn,
   input  logic [ADDR_W-1:0] LdAddr,
   input  logic [DATA_W-1:0] LdData
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   idm_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              ack_q, ack_d;
   logic              err_q, err_d;

   logic addr_in_range;
   logic ld_in_range;
   logic ram_ld_en, ram_wr_en, ram_rd_en;

   assign addr_in_range = {1'b0, addr_q} < DEPTH_L;
   assign ld_in_range   = {1'b0, LdAddr} < DEPTH_L;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      ram_ld_en = 1'b0;
      ram_wr_en = 1'b0;
      ram_rd_en = 1'b0;
      case (state_q)
         IDLE: begin
            ram_ld_en = LdEn && ld_in_range;
            if (Req) begin
               wr_d    = IDMWrite;
               addr_d  = Addr;
               wdata_d = WData;
               if (WAIT_CYC == 0) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(WAIT_CYC);
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = RESP;
         end
         RESP: begin
            // Out-of-range access suppresses the write and clears RData.
            ack_d     = 1'b1;
            err_d     = !addr_in_range;
            ram_wr_en = (wr_q == IDM_WR) && addr_in_range;
            ram_rd_en = (wr_q == IDM_RD) || !addr_in_range;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wr_q    <= IDM_RD;
         addr_q  <= '0;
         wdata_q <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

   idm_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk     (CLK),
      .rst_n   (RST_n),
      .ld_en   (ram_ld_en),
      .ld_addr (LdAddr),
      .ld_data (LdData),
      .wr_en   (ram_wr_en),
      .wr_addr (addr_q),
      .wr_data (wdata_q),
      .rd_en   (ram_rd_en),
      .rd_zero (!addr_in_range),
      .rd_addr (addr_q),
      .rd_data (RData)
   );

   assign Ack  = ack_q;
   assign Err  = err_q;
   assign Busy = (state_q != IDLE);

endmodule
